// File: rtl/bcd_seg_counter_pkg.sv
// Shared constants and helpers for the BCD 7-segment counter: active-low
// segment codes (a..g on bits 7..1, dp on bit 0) and BCD utilities.
package bcd_seg_pkg;

    localparam logic [7:0] SEG_BLANK = 8'hFF;
    localparam logic [7:0] SEG_0     = 8'h03;
    localparam logic [7:0] SEG_1     = 8'h9F;
    localparam logic [7:0] SEG_2     = 8'h25;
    localparam logic [7:0] SEG_3     = 8'h0D;
    localparam logic [7:0] SEG_4     = 8'h99;
    localparam logic [7:0] SEG_5     = 8'h49;
    localparam logic [7:0] SEG_6     = 8'h41;
    localparam logic [7:0] SEG_7     = 8'h1F;
    localparam logic [7:0] SEG_8     = 8'h01;
    localparam logic [7:0] SEG_9     = 8'h09;

    function automatic logic [7:0] bcd_to_seg(input logic [3:0] d);
        case (d)
            4'd0:    return SEG_0;
            4'd1:    return SEG_1;
            4'd2:    return SEG_2;
            4'd3:    return SEG_3;
            4'd4:    return SEG_4;
            4'd5:    return SEG_5;
            4'd6:    return SEG_6;
            4'd7:    return SEG_7;
            4'd8:    return SEG_8;
            4'd9:    return SEG_9;
            default: return SEG_BLANK;
        endcase
    endfunction

    function automatic logic bcd_is_valid(input logic [3:0] d);
        return d <= 4'd9;
    endfunction

    // Elaboration-time conversion of an integer to packed BCD (8 digits max).
    function automatic logic [31:0] int_to_bcd(input int unsigned v);
        logic [31:0] r;
        int unsigned t;
        r = '0;
        t = v;
        for (int i = 0; i < 8; i++) begin
            r[4*i +: 4] = 4'(t % 10);
            t = t / 10;
        end
        return r;
    endfunction

endpackage

// File: rtl/bcd_seg_counter_if.sv
// Control/display bundle of the BCD counter: switches in, count/segments/LEDs out.
interface bcd_seg_counter_if #(
    parameter int DIGITS = 2
);
    logic                  en;
    logic                  up_dn;
    logic                  clr;
    logic                  load;
    logic [4*DIGITS-1:0]   load_val;
    logic [4*DIGITS-1:0]   bcd;
    logic [8*DIGITS-1:0]   seg;
    logic                  tick;
    logic                  wrap;
    logic                  wrap_led;
    logic                  load_err;

    modport master (
        output en, up_dn, clr, load, load_val,
        input  bcd, seg, tick, wrap, wrap_led, load_err
    );

    modport slave (
        input  en, up_dn, clr, load, load_val,
        output bcd, seg, tick, wrap, wrap_led, load_err
    );
endinterface

// File: rtl/bcd_seg_counter_digit.sv
// One BCD digit of the counter chain: clear > load > step, with ripple
// carry (up) / borrow (down) produced combinationally from the held value.
module bcd_digit (
    input  logic       clk,
    input  logic       rst,
    input  logic       clr,
    input  logic       ld,
    input  logic [3:0] ld_val,
    input  logic       step,
    input  logic       up_dn,
    input  logic       cin,
    output logic [3:0] q,
    output logic       cout
);
    logic [3:0] q_q, q_d;

    always_comb begin
        q_d = q_q;
        if (clr) begin
            q_d = 4'd0;
        end else if (ld) begin
            q_d = ld_val;
        end else if (step && cin) begin
            if (up_dn) q_d = (q_q == 4'd9) ? 4'd0 : q_q + 4'd1;
            else       q_d = (q_q == 4'd0) ? 4'd9 : q_q - 4'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) q_q <= 4'd0;
        else     q_q <= q_d;
    end

    assign q    = q_q;
    assign cout = cin & (up_dn ? (q_q == 4'd9) : (q_q == 4'd0));
endmodule

// File: rtl/bcd_seg_counter.sv
// Multi-digit BCD counter with prescaler, modulo wrap and 7-segment decode.
// Optional leading-zero blanking is enabled by defining BCD_SEG_LZ_BLANK_EN.
module bcd_seg_counter
    import bcd_seg_pkg::*;
#(
    parameter int DIGITS = 2,
    parameter int DIV    = 50000000,
    parameter int MODULO = 100
) (
    input  logic                clk,
    input  logic                rst,
    bcd_seg_counter_if.slave    bus
);
    localparam int                  PW        = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [PW-1:0]       PRESC_MAX = PW'(DIV - 1);
    localparam logic [31:0]         TOP_W     = int_to_bcd(MODULO - 1);
    localparam logic [4*DIGITS-1:0] TOP_BCD   = TOP_W[4*DIGITS-1:0];

    logic [PW-1:0]       presc_q, presc_d;
    logic                wrap_q, wrap_d;
    logic                wrap_led_q, wrap_led_d;
    logic                load_err_q, load_err_d;
    logic [4*DIGITS-1:0] bcd_q;
    logic [DIGITS:0]     carry;
    logic                tick, ld_ok, wrap_cond, count_step;
    logic                digit_ld, digit_step;
    logic [4*DIGITS-1:0] digit_ld_val;

    assign tick = bus.en & (presc_q == PRESC_MAX);

    // With valid nibbles, BCD ordering equals numeric ordering, so a plain
    // unsigned compare against MODULO-1 in BCD checks the range.
    always_comb begin
        ld_ok = 1'b1;
        for (int i = 0; i < DIGITS; i++)
            ld_ok = ld_ok & bcd_is_valid(bus.load_val[4*i +: 4]);
        ld_ok = ld_ok & (bus.load_val <= TOP_BCD);
    end

    // Borrow out of the top digit means every digit is 0.
    assign wrap_cond    = bus.up_dn ? (bcd_q == TOP_BCD) : carry[DIGITS];
    assign count_step   = tick & ~bus.clr & ~bus.load;
    assign digit_ld     = (bus.load & ld_ok) | (count_step & wrap_cond);
    assign digit_ld_val = bus.load ? bus.load_val : (bus.up_dn ? '0 : TOP_BCD);
    assign digit_step   = count_step & ~wrap_cond;
    assign carry[0]     = 1'b1;

    for (genvar i = 0; i < DIGITS; i++) begin : g_digit
        bcd_digit u_digit (
            .clk    (clk),
            .rst    (rst),
            .clr    (bus.clr),
            .ld     (digit_ld),
            .ld_val (digit_ld_val[4*i +: 4]),
            .step   (digit_step),
            .up_dn  (bus.up_dn),
            .cin    (carry[i]),
            .q      (bcd_q[4*i +: 4]),
            .cout   (carry[i+1])
        );
    end

    always_comb begin
        presc_d = presc_q;
        if (bus.clr || bus.load) presc_d = '0;
        else if (bus.en)         presc_d = (presc_q == PRESC_MAX) ? '0 : presc_q + PW'(1);

        wrap_d     = count_step & wrap_cond;
        wrap_led_d = wrap_led_q;
        if (bus.clr)         wrap_led_d = 1'b0;
        else if (count_step) wrap_led_d = wrap_cond;
        load_err_d = ~bus.clr & bus.load & ~ld_ok;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            presc_q    <= '0;
            wrap_q     <= 1'b0;
            wrap_led_q <= 1'b0;
            load_err_q <= 1'b0;
        end else begin
            presc_q    <= presc_d;
            wrap_q     <= wrap_d;
            wrap_led_q <= wrap_led_d;
            load_err_q <= load_err_d;
        end
    end

`ifdef BCD_SEG_LZ_BLANK_EN
    logic zero_run;
    always_comb begin
        bus.seg  = '0;
        zero_run = 1'b1;
        for (int i = DIGITS - 1; i >= 0; i--) begin
            zero_run = zero_run & (bcd_q[4*i +: 4] == 4'd0);
            if (i > 0 && zero_run) bus.seg[8*i +: 8] = SEG_BLANK;
            else                   bus.seg[8*i +: 8] = bcd_to_seg(bcd_q[4*i +: 4]);
        end
    end
`else
    always_comb begin
        bus.seg = '0;
        for (int i = 0; i < DIGITS; i++)
            bus.seg[8*i +: 8] = bcd_to_seg(bcd_q[4*i +: 4]);
    end
`endif

    assign bus.bcd      = bcd_q;
    assign bus.tick     = tick;
    assign bus.wrap     = wrap_q;
    assign bus.wrap_led = wrap_led_q;
    assign bus.load_err = load_err_q;
endmodule

// File: tb/tb_bcd_seg_counter.sv
// Bench for bcd_seg_counter: two instances (MODULO 100 and 60, DIV 4) share
// stimulus and are compared every cycle against an integer reference model.
module tb_bcd_seg_counter;
    localparam int DIGITS = 2;
    localparam int DIV    = 4;
    localparam int MOD_A  = 100;
    localparam int MOD_B  = 60;

    logic clk = 1'b0;
    logic rst;
    logic en_s, up_s, clr_s, load_s;
    logic [7:0] lv_s;

    bcd_seg_counter_if #(.DIGITS(DIGITS)) ifa ();
    bcd_seg_counter_if #(.DIGITS(DIGITS)) ifb ();

    bcd_seg_counter #(.DIGITS(DIGITS), .DIV(DIV), .MODULO(MOD_A)) dut_a (
        .clk (clk), .rst (rst), .bus (ifa)
    );
    bcd_seg_counter #(.DIGITS(DIGITS), .DIV(DIV), .MODULO(MOD_B)) dut_b (
        .clk (clk), .rst (rst), .bus (ifb)
    );

    always #5 clk = ~clk;

    // Reference model state: plain integers per instance, shared prescaler.
    int mval[2];
    bit mwrap[2], mled[2], merr[2];
    int presc = 0;
    int n_checks = 0;
    int n_errors = 0;

    function automatic int mod_of(input int k);
        return (k == 0) ? MOD_A : MOD_B;
    endfunction

    function automatic logic [7:0] seg_of(input int d);
        case (d)
            0: return 8'h03;  1: return 8'h9F;  2: return 8'h25;  3: return 8'h0D;
            4: return 8'h99;  5: return 8'h49;  6: return 8'h41;  7: return 8'h1F;
            8: return 8'h01;  9: return 8'h09;  default: return 8'hFF;
        endcase
    endfunction

    function automatic logic [15:0] exp_seg(input int v);
        logic [15:0] r;
        r = {seg_of((v / 10) % 10), seg_of(v % 10)};
`ifdef BCD_SEG_LZ_BLANK_EN
        if ((v / 10) % 10 == 0) r[15:8] = 8'hFF;
`endif
        return r;
    endfunction

    function automatic logic [7:0] exp_bcd(input int v);
        return {4'((v / 10) % 10), 4'(v % 10)};
    endfunction

    function automatic bit lv_valid(input logic [7:0] lv, input int m);
        int hi, lo;
        hi = int'(lv[7:4]);
        lo = int'(lv[3:0]);
        return (hi <= 9) && (lo <= 9) && (hi * 10 + lo < m);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic apply();
        ifa.en = en_s;   ifb.en = en_s;
        ifa.up_dn = up_s; ifb.up_dn = up_s;
        ifa.clr = clr_s; ifb.clr = clr_s;
        ifa.load = load_s; ifb.load = load_s;
        ifa.load_val = lv_s; ifb.load_val = lv_s;
    endtask

    task automatic model_edge();
        bit tk;
        tk = en_s && (presc == DIV - 1);
        for (int k = 0; k < 2; k++) begin
            mwrap[k] = 0;
            merr[k]  = 0;
            if (rst) begin
                mval[k] = 0; mled[k] = 0;
            end else if (clr_s) begin
                mval[k] = 0; mled[k] = 0;
            end else if (load_s) begin
                if (lv_valid(lv_s, mod_of(k))) mval[k] = int'(lv_s[7:4]) * 10 + int'(lv_s[3:0]);
                else                           merr[k] = 1;
            end else if (tk) begin
                if (up_s) begin
                    mwrap[k] = (mval[k] == mod_of(k) - 1);
                    mval[k]  = (mval[k] + 1) % mod_of(k);
                end else begin
                    mwrap[k] = (mval[k] == 0);
                    mval[k]  = (mval[k] + mod_of(k) - 1) % mod_of(k);
                end
                mled[k] = mwrap[k];
            end
        end
        if (rst || clr_s || load_s) presc = 0;
        else if (en_s)              presc = (presc + 1) % DIV;
    endtask

    task automatic check_outs(input int k, input logic [7:0] b, input logic [15:0] s,
                              input logic w, input logic l, input logic e);
        chk($sformatf("bcd%0d", k),      32'(b), 32'(exp_bcd(mval[k])));
        chk($sformatf("seg%0d", k),      32'(s), 32'(exp_seg(mval[k])));
        chk($sformatf("wrap%0d", k),     32'(w), 32'(mwrap[k]));
        chk($sformatf("wrap_led%0d", k), 32'(l), 32'(mled[k]));
        chk($sformatf("load_err%0d", k), 32'(e), 32'(merr[k]));
    endtask

    task automatic step();
        bit tk;
        apply();
        #1;
        tk = en_s && (presc == DIV - 1);
        chk("tick0", 32'(ifa.tick), 32'(tk));
        chk("tick1", 32'(ifb.tick), 32'(tk));
        @(posedge clk);
        model_edge();
        #1;
        check_outs(0, ifa.bcd, ifa.seg, ifa.wrap, ifa.wrap_led, ifa.load_err);
        check_outs(1, ifb.bcd, ifb.seg, ifb.wrap, ifb.wrap_led, ifb.load_err);
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    // Advance with en=1 until the prescaler reaches target; bounded.
    task automatic run_to_presc(input int target);
        int guard;
        guard = 0;
        en_s = 1'b1;
        while (presc != target && guard < 2 * DIV) begin
            step();
            guard++;
        end
        chk("presc_reach", 32'(presc == target), 32'd1);
    endtask

    task automatic pulse_load(input logic [7:0] v);
        load_s = 1'b1; lv_s = v;
        step();
        load_s = 1'b0;
    endtask

    initial begin
        rst = 1'b1; en_s = 1'b0; up_s = 1'b1; clr_s = 1'b0; load_s = 1'b0; lv_s = 8'h00;
        mval = '{0, 0}; mwrap = '{0, 0}; mled = '{0, 0}; merr = '{0, 0};
        steps(2);
        rst = 1'b0; en_s = 1'b1;
        steps(40);
        chk("bcd_after10", 32'(ifa.bcd), 32'h10);
        chk("seg_after10", 32'(ifa.seg), 32'h9F03);

        // Up wrap from 99 (rejected on the MODULO 60 instance).
        pulse_load(8'h99);
        steps(8);
        // Down wrap from 0, then up wrap from MODULO-1.
        up_s = 1'b0;
        pulse_load(8'h00);
        steps(4);
        up_s = 1'b1;
        steps(4);
        // Invalid and valid loads; valid load restarts the prescaler.
        pulse_load(8'h7A);
        pulse_load(8'h75);
        pulse_load(8'h42);
        steps(3);
        chk("no_tick_before_4", 32'(ifa.bcd), 32'h42);
        steps(1);
        chk("tick_after_load", 32'(ifa.bcd), 32'h43);

        // clr + load + tick together, then load + tick.
        run_to_presc(DIV - 1);
        clr_s = 1'b1; load_s = 1'b1; lv_s = 8'h33;
        step();
        clr_s = 1'b0; load_s = 1'b0;
        chk("clr_wins", 32'(ifb.bcd), 32'h00);
        run_to_presc(DIV - 1);
        pulse_load(8'h25);

        // Enable low holds everything.
        en_s = 1'b0;
        steps(10);
        en_s = 1'b1;

        // Reset mid-prescaler.
        run_to_presc(2);
        rst = 1'b1;
        step();
        rst = 1'b0;
        steps(DIV);

        // Randomized traffic.
        for (int i = 0; i < 400; i++) begin
            en_s   = ($urandom_range(0, 9) != 0);
            up_s   = 1'($urandom_range(0, 1));
            clr_s  = ($urandom_range(0, 39) == 0);
            load_s = ($urandom_range(0, 14) == 0);
            lv_s   = 8'($urandom_range(0, 255));
            rst    = ($urandom_range(0, 99) == 0);
            step();
        end
        rst = 1'b0; clr_s = 1'b0; load_s = 1'b0;
        steps(2);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/bcd_seg_counter.md
Name: bcd_seg_counter

Overview:
Parametrised multi-digit decimal counter with 7-segment outputs for board-level display. All logic runs in the single `clk` domain; a prescaler produces a one-cycle count-enable strobe, and no derived clocks are used. Supports:
- up/down counting
- synchronous load and clear
- programmable modulo
- a wrap indicator for an LED

Sits between board clock/switches and the segment/LED pins.

Parameters:
- DIGITS, 2, number of BCD digits (1..8)
- DIV, 50000000, clk cycles per count step (>=1); prescaler width $clog2(DIV), min 1
- MODULO, 100, count range 0..MODULO-1; must satisfy 2 <= MODULO <= 10^DIGITS

Ports:
- clk  in  1  system clock
- rst  in  1  reset, synchronous, active-high
- en  in  1  count enable; prescaler runs only while en=1
- up_dn  in  1  1=count up, 0=count down; sampled on the tick cycle
- clr  in  1  synchronous clear of count and prescaler
- load  in  1  synchronous load strobe
- load_val  in  4*DIGITS  BCD value to load; digit 0 in [3:0]
- bcd  out  4*DIGITS  current count, BCD, registered
- seg  out  8*DIGITS  segment patterns; digit i in [8i+7:8i]
- tick  out  1  one-cycle pulse when the prescaler expires
- wrap  out  1  one-cycle pulse on the cycle after a wrap update
- wrap_led  out  1  level; set on wrap, cleared on the next non-wrapping step
- load_err  out  1  one-cycle pulse when a load was rejected

Behaviour:
- Reset values: bcd=0, prescaler=0, tick=0, wrap=0, wrap_led=0, load_err=0.
- Priority per cycle: rst > clr > load > count step.
- clr: bcd<=0, prescaler<=0, wrap_led<=0.
- load, valid value: bcd<=load_val, prescaler<=0.
  - Valid means every nibble <=9 and the decimal value < MODULO.
- load, invalid value: bcd unchanged, prescaler<=0, load_err=1 next cycle.
- Prescaler behaviour:
  - Increments while en=1.
  - At DIV-1 it returns to 0 and tick=1 in that same cycle (combinational from state).
  - en=0 holds the prescaler.
  - DIV=1 gives tick every en cycle.
- Count step: occurs on a cycle with tick=1 and no clr/load.
  - Up: bcd+1 with per-digit carry (9->0, carry out).
    - At MODULO-1 the next value is 0 (wrap).
  - Down: bcd-1 with per-digit borrow (0->9).
    - At 0 the next value is MODULO-1 (wrap).
  - Latency: bcd updates at the clock edge ending the tick cycle; wrap and wrap_led become visible in the same cycle as the new bcd.
  - wrap_led is set on a wrapping step and cleared on any non-wrapping step.
- Segment encoding:
  - Active-low, bit7=a ... bit1=g, bit0=dp, dp always off.
  - Codes: 0=0x03, 1=0x9F, 2=0x25, 3=0x0D, 4=0x99, 5=0x49, 6=0x41, 7=0x1F, 8=0x01, 9=0x09.
  - Non-BCD nibble gives 0xFF (blank); unreachable in normal operation.
- seg is combinational from registered bcd, with zero latency to bcd.
- Changing up_dn between ticks has no effect until the next tick.
- rst asserted mid-count returns all outputs to reset values on the next edge; no partial step.

Optional Feature:
- Macro: BCD_SEG_LZ_BLANK_EN.
- Defined: leading-zero blanking.
  - Each digit i>0 whose value and all higher digits are 0 outputs 0xFF.
  - Digit 0 is always displayed.
  - Example: DIGITS=3, value 7 gives seg[23:8]=0xFFFF.
- Undefined: all digits always displayed.
- bcd output is identical in both cases.

Decomposition:
- Package bcd_seg_pkg holds:
  - localparam SEG_BLANK=8'hFF
  - segment code constants SEG_0..SEG_9
  - function bcd_to_seg(4-bit) -> 8-bit
  - function bcd_is_valid(nibble)
- Sub-module bcd_digit:
  - inputs: clk, rst, clr, ld, ld_val[3:0], step, up_dn, cin/bin
  - outputs: q[3:0], carry/borrow out
  - instantiated DIGITS times via generate.
- Modulo compare, wrap substitution and prescaler live in the top module.

Test Plan:
- DIV=4, MODULO=100, en=1, up: after rst, tick every 4th cycle; after 10 ticks bcd=0x10, seg[15:0]=0x9F03.
- Up from load 0x99: next tick gives bcd=0x00, wrap=1 for one cycle, wrap_led=1; following tick gives 0x01, wrap_led=0.
- MODULO=60, down from 0x00: tick gives bcd=0x59, wrap=1; up from 0x59 gives 0x00.
- Invalid loads:
  - load_val=0x7A gives load_err=1, bcd unchanged.
  - MODULO=60 with load_val=0x75 gives load_err=1.
  - load_val=0x42 gives bcd=0x42, prescaler restarted so the next tick is 4 cycles later.
- Simultaneous events:
  - clr+load+tick in the same cycle gives bcd=0, no wrap.
  - load+tick gives bcd=load_val.
  - en=0 for 10 cycles gives no tick and no change.
- rst mid-prescaler (count 2) then release: first tick exactly DIV cycles later.
- With BCD_SEG_LZ_BLANK_EN: value 0x05 gives seg[15:8]=0xFF.
